sha256_msg_loader: RTL and testbench

- Host-side companion to the SHA-256 memory-master core; it drives the opposite end of the core's shared word memory.
- It writes a NUM_OF_WORDS message from a valid/ready input stream into memory at input_addr, then pulses sha_start and waits for the core to finish.
- It then reads the 8-word digest back from hash_addr and emits it on a valid/ready output stream.
- It owns the memory port except while the core runs; an external 2:1 mux keyed on owns_mem selects the master.

---
 rtl/sha256_pkg.sv | 51 +++++
 rtl/sha256_msg_loader_if.sv | 52 +++++
 rtl/sha256_msg_loader.sv | 192 +++++++++++++++++++
 tb/tb_sha256_msg_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the memory-master core and its host-side
// loader: digest geometry, loader FSM encoding, the initial hash value and
// the round constants, plus 16-bit wrapping word-address arithmetic.
package sha256_pkg;

  localparam int unsigned DIGEST_WORDS = 8;

  // Loader FSM encoding. The explicit 3-bit values match the original
  // encoding so that state dumps read the same as before.
  typedef enum logic [2:0] {
    LDR_IDLE      = 3'd0,
    LDR_LOAD      = 3'd1,
    LDR_KICK      = 3'd2,
    LDR_WAIT_BUSY = 3'd3,
    LDR_WAIT_DONE = 3'd4,
    LDR_RD_ADDR   = 3'd5,
    LDR_RD_DATA   = 3'd6,
    LDR_EMIT      = 3'd7
  } loader_state_e;

  localparam logic [31:0] SHA256_IV [DIGEST_WORDS] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Base + offset in the 16-bit word address space; wraps past 0xFFFF.
  function automatic logic [15:0] wrap_add(input logic [15:0] base,
                                           input logic [7:0]  offset);
    return base + {8'd0, offset};
  endfunction

endpackage

// File: rtl/sha256_msg_loader_if.sv
// Bundle of every non-clock/reset signal of the SHA-256 message loader:
// job control, message input stream, core handshake, shared word-memory
// port and digest output stream.
//   master : the loader itself
//   slave  : the surrounding system (host, core, memory mux, sink)
interface sha256_msg_loader_if;
  import sha256_pkg::*;

  // job control
  logic        start;
  logic [15:0] input_addr;
  logic [15:0] hash_addr;
  logic        done;
  logic        busy;
  logic        error;
  // message input stream
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  // core handshake
  logic        sha_start;
  logic        sha_done;
  // shared memory port
  logic        owns_mem;
  logic        memory_clk;
  logic        memory_we;
  logic [15:0] memory_addr;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;
  // digest output stream
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    input  start, input_addr, hash_addr, in_valid, in_data, sha_done,
           memory_read_data, out_ready,
    output done, busy, error, in_ready, sha_start, owns_mem, memory_clk,
           memory_we, memory_addr, memory_write_data, out_valid, out_data,
           out_last
  );

  modport slave (
    output start, input_addr, hash_addr, in_valid, in_data, sha_done,
           memory_read_data, out_ready,
    input  done, busy, error, in_ready, sha_start, owns_mem, memory_clk,
           memory_we, memory_addr, memory_write_data, out_valid, out_data,
           out_last
  );

endinterface

// File: rtl/sha256_msg_loader.sv
// Host-side companion to the SHA-256 memory-master core. Writes a
// NUM_OF_WORDS message from the input stream into the shared word memory,
// kicks the core, waits for it to finish, then reads the 8-word digest back
// and streams it out (H0 first, out_last on H7).
//   clk  : clock, also forwarded as bus.memory_clk
//   rst  : asynchronous active-high reset
//   bus  : sha256_msg_loader_if.master (control, streams, memory port)
// All outputs are registered except memory_clk and in_ready.
module sha256_msg_loader
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_OF_WORDS   = 40,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  sha256_msg_loader_if.master bus
);

  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  WLAST = 8'(NUM_OF_WORDS - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RLAST = 3'(DIGEST_WORDS - 1);

  loader_state_e state;

  logic [7:0]    wcnt;
  logic [2:0]    rcnt;
  logic [2:0]    rcnt_nxt;
  logic [TW-1:0] tcnt;
  logic [15:0]   in_base;
  logic [15:0]   hash_base;
  logic          timed_out;

  logic          sha_start_q;
  logic          owns_mem_q;
  logic          mem_we_q;
  logic [15:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic          out_valid_q;
  logic [31:0]   out_data_q;
  logic          out_last_q;
  logic          done_q;
  logic          busy_q;
  logic          error_q;

  assign rcnt_nxt  = rcnt + 3'd1;
  assign timed_out = (tcnt == TLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LDR_IDLE;
      wcnt        <= '0;
      rcnt        <= '0;
      tcnt        <= '0;
      in_base     <= '0;
      hash_base   <= '0;
      sha_start_q <= 1'b0;
      owns_mem_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // single-cycle strobes
      sha_start_q <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;

      case (state)
        LDR_IDLE: begin
          owns_mem_q <= 1'b1;
          if (bus.start) begin
            in_base   <= bus.input_addr;
            hash_base <= bus.hash_addr;
            error_q   <= 1'b0;
            wcnt      <= '0;
            busy_q    <= 1'b1;
            state     <= LDR_LOAD;
          end
        end

        LDR_LOAD: begin
          // in_ready is high throughout LOAD, so in_valid alone is a beat
          if (bus.in_valid) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= wrap_add(in_base, wcnt);
            mem_wdata_q <= bus.in_data;
            wcnt        <= wcnt + 8'd1;
            if (wcnt == WLAST) begin
              state <= LDR_KICK;
            end
          end
        end

        LDR_KICK: begin
          // The last write is on the port during this cycle; the memory
          // is handed to the core only once that write has landed.
          sha_start_q <= 1'b1;
          owns_mem_q  <= 1'b0;
          tcnt        <= '0;
          state       <= LDR_WAIT_BUSY;
        end

        LDR_WAIT_BUSY: begin
          if (!bus.sha_done) begin
            tcnt  <= '0;
            state <= LDR_WAIT_DONE;
          end else if (timed_out) begin
            error_q    <= 1'b1;
            done_q     <= 1'b1;
            owns_mem_q <= 1'b1;
            busy_q     <= 1'b0;
            state      <= LDR_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        LDR_WAIT_DONE: begin
          if (bus.sha_done) begin
            owns_mem_q <= 1'b1;
            rcnt       <= '0;
            mem_addr_q <= hash_base;
            state      <= LDR_RD_ADDR;
          end else if (timed_out) begin
            error_q    <= 1'b1;
            done_q     <= 1'b1;
            owns_mem_q <= 1'b1;
            busy_q     <= 1'b0;
            state      <= LDR_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        // memory_addr was loaded on entry, so it is presented throughout
        // this cycle; read data returns during RD_DATA.
        LDR_RD_ADDR: begin
          state <= LDR_RD_DATA;
        end

        LDR_RD_DATA: begin
          out_data_q  <= bus.memory_read_data;
          out_valid_q <= 1'b1;
          out_last_q  <= (rcnt == RLAST);
          state       <= LDR_EMIT;
        end

        LDR_EMIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (rcnt == RLAST) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= LDR_IDLE;
            end else begin
              rcnt       <= rcnt_nxt;
              mem_addr_q <= wrap_add(hash_base, {5'd0, rcnt_nxt});
              state      <= LDR_RD_ADDR;
            end
          end
        end

        default: begin
          state <= LDR_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready          = (state == LDR_LOAD);
  assign bus.memory_clk        = clk;
  assign bus.sha_start         = sha_start_q;
  assign bus.owns_mem          = owns_mem_q;
  assign bus.memory_we         = mem_we_q;
  assign bus.memory_addr       = mem_addr_q;
  assign bus.memory_write_data = mem_wdata_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_data          = out_data_q;
  assign bus.out_last          = out_last_q;
  assign bus.done              = done_q;
  assign bus.busy              = busy_q;
  assign bus.error             = error_q;

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Testbench for sha256_msg_loader: word memory, a behavioural stand-in for
// the SHA core (writes the known "abcd" digest into memory), a scoreboard
// of expected writes / start pulses / digest words / done events, and a
// monitor that pops and compares whenever the DUT presents them.
module tb_sha256_msg_loader;
  import sha256_pkg::*;

  localparam int unsigned NW  = 4;
  localparam int unsigned TMO = 16;

  localparam logic [31:0] DIG [DIGEST_WORDS] = '{
    32'h88d4266f, 32'hd4e6338d, 32'h13b845fc, 32'hf289579d,
    32'h209c8978, 32'h23b9217d, 32'ha3e16193, 32'h6f031589
  };

  typedef struct packed { logic [15:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic [31:0] d; logic l; } out_t;
  typedef struct packed { logic err; int lat; } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_msg_loader_if bus();

  sha256_msg_loader #(.NUM_OF_WORDS(NW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // scoreboard queues
  wr_t   wr_q[$];
  out_t  out_q[$];
  done_t done_q[$];
  bit    start_q[$];
  int    zero_req = 0;

  // ---------------- memory + core stand-in ----------------
  logic [31:0] mem [65536];
  logic [31:0] rd_q      = '0;
  logic        sha_done_q = 1'b1;
  logic        core_en   = 1'b1;
  logic [15:0] core_hash = '0;
  int          core_state = 0;
  int          core_cnt   = 0;

  assign bus.sha_done         = sha_done_q;
  assign bus.memory_read_data = rd_q;

  always @(posedge clk) begin
    if (bus.owns_mem && bus.memory_we) mem[bus.memory_addr] <= bus.memory_write_data;
    rd_q <= mem[bus.memory_addr];
    if (core_state == 0) begin
      if (bus.sha_start && core_en) begin
        core_state <= 1;
        core_cnt   <= 0;
        sha_done_q <= 1'b0;
      end
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == 4) begin
        for (int i = 0; i < DIGEST_WORDS; i++) mem[core_hash + 16'(i)] <= DIG[i];
        sha_done_q <= 1'b1;
        core_state <= 0;
      end
    end
  end

  // ---------------- output sink (backpressure) ----------------
  logic stall_en   = 1'b0;
  int   hs_cnt     = 0;
  int   stall_left = 5;
  logic hs_now;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      hs_now = bus.out_valid && bus.out_ready;
      if (bus.done) begin
        hs_cnt     = 0;
        stall_left = 5;
      end
      @(posedge clk);
      #1;
      if (hs_now) hs_cnt++;
      if (stall_en && bus.out_valid && hs_cnt == 3 && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  int          zero_served = 0;
  int          since_start = 0;
  logic        prev_stall  = 1'b0;
  logic        prev_start  = 1'b0;
  logic        prev_done   = 1'b0;
  logic [31:0] prev_data   = '0;
  logic        prev_last   = 1'b0;
  logic [15:0] prev_addr   = '0;
  wr_t         w;
  out_t        o;
  done_t       dn;

  initial begin
    forever begin
      @(negedge clk);
      since_start++;

      if (zero_req != zero_served) begin
        zero_served = zero_req;
        chk("zero_ctrl", 64'({bus.sha_start, bus.owns_mem, bus.memory_we,
            bus.out_valid, bus.out_last, bus.done, bus.busy, bus.error,
            bus.in_ready}), 64'd0);
        chk("zero_addr",  64'(bus.memory_addr), 64'd0);
        chk("zero_wdata", 64'(bus.memory_write_data), 64'd0);
        chk("zero_odata", 64'(bus.out_data), 64'd0);
      end

      if (bus.memory_we) begin
        chk("write_owns_mem", 64'(bus.owns_mem), 64'd1);
        chk("write_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          chk("write_addr", 64'(bus.memory_addr), 64'(w.a));
          chk("write_data", 64'(bus.memory_write_data), 64'(w.d));
        end
      end

      if (bus.sha_start) begin
        chk("start_single", 64'(prev_start), 64'd0);
        chk("start_owns_mem", 64'(bus.owns_mem), 64'd0);
        chk("start_no_write", 64'(bus.memory_we), 64'd0);
        chk("start_expected", 64'(start_q.size() != 0), 64'd1);
        if (start_q.size() != 0) void'(start_q.pop_front());
        since_start = 0;
      end

      if (prev_stall) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_data",  64'(bus.out_data), 64'(prev_data));
        chk("hold_last",  64'(bus.out_last), 64'(prev_last));
        chk("hold_addr",  64'(bus.memory_addr), 64'(prev_addr));
      end

      if (bus.out_valid && bus.out_ready) begin
        chk("out_expected", 64'(out_q.size() != 0), 64'd1);
        if (out_q.size() != 0) begin
          o = out_q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(o.d));
          chk("out_last", 64'(bus.out_last), 64'(o.l));
        end
      end

      if (bus.done) begin
        chk("done_single", 64'(prev_done), 64'd0);
        chk("done_expected", 64'(done_q.size() != 0), 64'd1);
        if (done_q.size() != 0) begin
          dn = done_q.pop_front();
          chk("done_error", 64'(bus.error), 64'(dn.err));
          if (dn.lat >= 0) chk("timeout_latency", 64'(since_start), 64'(dn.lat));
        end
      end

      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      prev_addr  = bus.memory_addr;
      prev_start = bus.sha_start;
      prev_done  = bus.done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input int gap);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("in_ready_seen", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (gap) cycle();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(bus.done), 64'd1);
    cycle();
  endtask

  task automatic run_job(input logic [15:0] ia, input logic [15:0] ha,
                         input int gap, input bit core_on, input bit stall);
    logic [31:0] d;
    core_en   = core_on;
    core_hash = ha;
    stall_en  = stall;
    for (int k = 0; k < NW; k++) begin
      d = 32'h11111111 * 32'(k + 1);
      wr_q.push_back('{a: ia + 16'(k), d: d});
    end
    start_q.push_back(1'b1);
    if (core_on) begin
      for (int i = 0; i < DIGEST_WORDS; i++)
        out_q.push_back('{d: DIG[i], l: (i == DIGEST_WORDS - 1)});
      done_q.push_back('{err: 1'b0, lat: -1});
    end else begin
      done_q.push_back('{err: 1'b1, lat: TMO});
    end
    bus.input_addr = ia;
    bus.hash_addr  = ha;
    bus.start      = 1'b1;
    cycle();
    bus.start      = 1'b0;
    for (int k = 0; k < NW; k++) send_word(32'h11111111 * 32'(k + 1), gap);
    wait_done();
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.input_addr = '0;
    bus.hash_addr  = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;

    // reset state
    repeat (2) cycle();
    zero_req++;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();
    chk("idle_owns_mem", 64'(bus.owns_mem), 64'd1);

    // back-to-back load + digest readback
    run_job(16'h0100, 16'h0200, 0, 1'b1, 1'b0);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    // backpressure on word 3
    run_job(16'h0100, 16'h0200, 0, 1'b1, 1'b1);
    // in_valid toggling every cycle
    run_job(16'h0300, 16'h0400, 1, 1'b1, 1'b0);
    // core never leaves idle -> timeout
    run_job(16'h0500, 16'h0600, 0, 1'b0, 1'b0);
    chk("error_sticky", 64'(bus.error), 64'd1);
    // address wrap; also shows error cleared by the next start
    run_job(16'hFFFE, 16'hFFFC, 0, 1'b1, 1'b0);
    chk("error_cleared", 64'(bus.error), 64'd0);

    // reset in the middle of LOAD after two beats
    core_en = 1'b1;
    wr_q.push_back('{a: 16'h0700, d: 32'h11111111});
    wr_q.push_back('{a: 16'h0701, d: 32'h22222222});
    bus.input_addr = 16'h0700;
    bus.hash_addr  = 16'h0800;
    bus.start      = 1'b1;
    cycle();
    bus.start      = 1'b0;
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    cycle();
    rst = 1'b1;
    zero_req++;
    repeat (2) cycle();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    repeat (3) cycle();
    bus.in_valid = 1'b0;
    chk("post_reset_busy", 64'(bus.busy), 64'd0);
    // a fresh job completes normally
    run_job(16'h0100, 16'h0200, 0, 1'b1, 1'b0);

    repeat (5) cycle();
    chk("left_writes",  64'(wr_q.size()), 64'd0);
    chk("left_outputs", 64'(out_q.size()), 64'd0);
    chk("left_dones",   64'(done_q.size()), 64'd0);
    chk("left_starts",  64'(start_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
